// File: rtl/vga_palette_regs.sv
// vga_palette_regs
//   Wishbone-slave colour palette register bank feeding the VGA colorizer.
//   Software writes a shadow copy of each palette entry; the shadow copy is
//   transferred to the active palette on a vertical-sync edge (when auto
//   commit is enabled and a colour write is outstanding) or on a forced
//   commit through CTRL. A 16-bit frame counter counts vsync edges.
//
//   Register map (word index idx = wb_adr_i[ADDR_LSB +: IDX_W]):
//     0 .. NUM_COLORS-1 : shadow colour entries, read/write
//     NUM_COLORS        : CTRL  bit0 auto (rw), bit1 force (w1, reads 0),
//                               bit2 pending (ro)
//                               [irq build] bit3 irq_en (rw), bit4 irq_stat (w1c)
//     NUM_COLORS+1      : FRAME [15:0] frame counter (ro, writes ignored)
//     other             : error termination
//
//   Ports:
//     clk, rst              system clock, synchronous active-high reset
//     wb_*                  Wishbone slave (32-bit data, byte-lane selects)
//     vert_sync             asynchronous vsync from the timing generator
//     active_colors         active palette, entry i at [i*COLOR_W +: COLOR_W]
//     commit_pulse          one-cycle strobe after the active palette updates
//     irq                   only when VGA_PALETTE_IRQ_EN is defined
//
//   Optional feature macro: VGA_PALETTE_IRQ_EN (commit interrupt).

module vga_palette_regs #(
   parameter int unsigned NUM_COLORS  = 4,
   parameter int unsigned COLOR_W     = 12,
   parameter logic [15:0] RESET_COLOR = 16'h00F8,
   parameter int unsigned ADDR_LSB    = 2,
   parameter logic        VSYNC_POL   = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   wb_adr_i,
   input  logic [31:0]                   wb_dat_i,
   input  logic [3:0]                    wb_sel_i,
   input  logic                          wb_we_i,
   input  logic                          wb_cyc_i,
   input  logic                          wb_stb_i,
   output logic [31:0]                   wb_dat_o,
   output logic                          wb_ack_o,
   output logic                          wb_err_o,
   input  logic                          vert_sync,
   output logic [NUM_COLORS*COLOR_W-1:0] active_colors,
   output logic                          commit_pulse
`ifdef VGA_PALETTE_IRQ_EN
   ,
   output logic                          irq
`endif
);

   localparam int unsigned        IDX_W        = $clog2(NUM_COLORS + 2);
   localparam logic [IDX_W-1:0]   CTRL_IDX     = IDX_W'(NUM_COLORS);
   localparam logic [IDX_W-1:0]   FRAME_IDX    = IDX_W'(NUM_COLORS + 1);
   localparam logic [COLOR_W-1:0] RST_COLOR    = RESET_COLOR[COLOR_W-1:0];
   localparam logic               HI_LANE_LIVE = (COLOR_W > 8);

   logic [COLOR_W-1:0] shadow_q [NUM_COLORS];
   logic [COLOR_W-1:0] shadow_d [NUM_COLORS];
   logic [COLOR_W-1:0] active_q [NUM_COLORS];
   logic [COLOR_W-1:0] active_d [NUM_COLORS];
   logic               auto_q, auto_d;
   logic               pending_q, pending_d;
   logic [15:0]        frame_cnt_q, frame_cnt_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic [31:0]        dat_q, dat_d;
   logic               commit_pulse_q, commit_pulse_d;
   logic               vs_meta_q, vs_meta_d;
   logic               vs_sync_q, vs_sync_d;
   logic               vs_hist_q, vs_hist_d;
`ifdef VGA_PALETTE_IRQ_EN
   logic               irq_en_q, irq_en_d;
   logic               irq_stat_q, irq_stat_d;
`endif

   logic [IDX_W-1:0]   idx;
   logic [COLOR_W-1:0] lane_mask;
   logic               req, addr_ok, rd, wr, ctrl_wr, force_wr;
   logic               lane_hit, vs_edge, commit;
   logic               unused_bits;

   assign idx         = wb_adr_i[ADDR_LSB +: IDX_W];
   // Address bits outside the index, data bits above the colour width and
   // lanes 3:2 are deliberately don't-care.
   assign unused_bits = ^{wb_adr_i, wb_dat_i, wb_sel_i};

   always_comb begin
      req      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
      addr_ok  = (idx <= FRAME_IDX);
      rd       = req & addr_ok & ~wb_we_i;
      wr       = req & addr_ok & wb_we_i;
      ctrl_wr  = wr & (idx == CTRL_IDX) & wb_sel_i[0];
      force_wr = ctrl_wr & wb_dat_i[1];
      // A lane only counts as a write if it reaches a stored bit.
      lane_hit = wb_sel_i[0] | (HI_LANE_LIVE & wb_sel_i[1]);
      vs_edge  = (vs_hist_q != VSYNC_POL) & (vs_sync_q == VSYNC_POL);
      commit   = (vs_edge & auto_q & pending_q) | force_wr;
      lane_mask = '0;
      for (int unsigned b = 0; b < COLOR_W; b++) begin
         lane_mask[b] = (b < 8) ? wb_sel_i[0] : wb_sel_i[1];
      end
   end

   always_comb begin
      shadow_d       = shadow_q;
      active_d       = active_q;
      auto_d         = auto_q;
      pending_d      = pending_q;
      frame_cnt_d    = vs_edge ? frame_cnt_q + 16'd1 : frame_cnt_q;
      ack_d          = req & addr_ok;
      err_d          = req & ~addr_ok;
      dat_d          = '0;
      commit_pulse_d = commit;
      vs_meta_d      = vert_sync;
      vs_sync_d      = vs_meta_q;
      vs_hist_d      = vs_sync_q;
`ifdef VGA_PALETTE_IRQ_EN
      irq_en_d       = irq_en_q;
      irq_stat_d     = irq_stat_q;
`endif

      // Commit copies the pre-edge shadow; a colour write on the same edge
      // lands in the shadow afterwards and re-arms pending below.
      if (commit) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end

      for (int unsigned i = 0; i < NUM_COLORS; i++) begin
         if (idx == IDX_W'(i)) begin
            if (rd) begin
               dat_d = 32'(shadow_q[i]);
            end
            if (wr) begin
               shadow_d[i] = (shadow_q[i] & ~lane_mask) |
                             (wb_dat_i[COLOR_W-1:0] & lane_mask);
               if (lane_hit) begin
                  pending_d = 1'b1;
               end
            end
         end
      end

      if (rd && (idx == CTRL_IDX)) begin
         dat_d[0] = auto_q;
         dat_d[2] = pending_q;
`ifdef VGA_PALETTE_IRQ_EN
         dat_d[3] = irq_en_q;
         dat_d[4] = irq_stat_q;
`endif
      end
      if (ctrl_wr) begin
         auto_d = wb_dat_i[0];
`ifdef VGA_PALETTE_IRQ_EN
         irq_en_d = wb_dat_i[3];
         if (wb_dat_i[4]) begin
            irq_stat_d = 1'b0;
         end
`endif
      end
      if (rd && (idx == FRAME_IDX)) begin
         dat_d[15:0] = frame_cnt_q;
      end
`ifdef VGA_PALETTE_IRQ_EN
      // Set after the clear so a same-cycle commit wins.
      if (commit) begin
         irq_stat_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_COLORS; i++) begin
            shadow_q[i] <= RST_COLOR;
            active_q[i] <= RST_COLOR;
         end
         auto_q         <= 1'b1;
         pending_q      <= 1'b0;
         frame_cnt_q    <= '0;
         ack_q          <= 1'b0;
         err_q          <= 1'b0;
         dat_q          <= '0;
         commit_pulse_q <= 1'b0;
         vs_meta_q      <= VSYNC_POL;
         vs_sync_q      <= VSYNC_POL;
         vs_hist_q      <= VSYNC_POL;
`ifdef VGA_PALETTE_IRQ_EN
         irq_en_q       <= 1'b0;
         irq_stat_q     <= 1'b0;
`endif
      end else begin
         shadow_q       <= shadow_d;
         active_q       <= active_d;
         auto_q         <= auto_d;
         pending_q      <= pending_d;
         frame_cnt_q    <= frame_cnt_d;
         ack_q          <= ack_d;
         err_q          <= err_d;
         dat_q          <= dat_d;
         commit_pulse_q <= commit_pulse_d;
         vs_meta_q      <= vs_meta_d;
         vs_sync_q      <= vs_sync_d;
         vs_hist_q      <= vs_hist_d;
`ifdef VGA_PALETTE_IRQ_EN
         irq_en_q       <= irq_en_d;
         irq_stat_q     <= irq_stat_d;
`endif
      end
   end

   always_comb begin
      active_colors = '0;
      for (int unsigned i = 0; i < NUM_COLORS; i++) begin
         active_colors[i*COLOR_W +: COLOR_W] = active_q[i];
      end
   end

   assign wb_dat_o     = dat_q;
   assign wb_ack_o     = ack_q;
   assign wb_err_o     = err_q;
   assign commit_pulse = commit_pulse_q;
`ifdef VGA_PALETTE_IRQ_EN
   assign irq          = irq_stat_q & irq_en_q;
`endif

endmodule

// File: doc/vga_palette_regs.md
Name: vga_palette_regs

Overview:
- Wishbone-slave colour register bank. Successor to the single-colour VGA control register: parametrised entry count and colour width.
- Adds readback, double-buffered (shadow/active) registers committed on the vertical-sync edge, a forced commit, a frame counter, and an error response for bad addresses.
- Sits between the Wishbone interconnect and the VGA colorizer. Single clock domain; the vsync input is synchronised internally.

Parameters:
- NUM_COLORS, 4, number of palette entries (1..16)
- COLOR_W, 12, bits per entry (1..16)
- RESET_COLOR, 12'h0F8, reset value of every shadow and active entry (truncated/zero-extended to COLOR_W)
- ADDR_LSB, 2, lowest word-index bit of wb_adr_i
- VSYNC_POL, 1'b1, active level of vert_sync

Ports:
- clk, input, 1, system clock
- rst, input, 1, synchronous active-high reset
- wb_adr_i, input, 32, byte address
- wb_dat_i, input, 32, write data
- wb_sel_i, input, 4, byte-lane selects
- wb_we_i, input, 1, write enable
- wb_cyc_i, input, 1, bus cycle
- wb_stb_i, input, 1, strobe
- wb_dat_o, output, 32, read data, registered
- wb_ack_o, output, 1, normal termination
- wb_err_o, output, 1, error termination
- vert_sync, input, 1, asynchronous vsync from the timing generator
- active_colors, output, NUM_COLORS*COLOR_W, active palette, entry i at [i*COLOR_W +: COLOR_W]
- commit_pulse, output, 1, one-cycle strobe when the active palette is updated

Behaviour:
- Reset (rst high at a clk edge) sets:
  - all shadow and active entries to RESET_COLOR
  - ctrl.auto = 1
  - pending = 0
  - frame_cnt = 0
  - wb_ack_o, wb_err_o, commit_pulse and wb_dat_o to 0
  - vsync synchroniser and history flops to VSYNC_POL, so no edge is seen until a full inactive-to-active transition

- Register map. idx = wb_adr_i[ADDR_LSB +: IDX_W], where IDX_W = clog2(NUM_COLORS+2); higher bits are ignored.
  - idx 0..NUM_COLORS-1: shadow colour, read/write. Readback is the shadow value, zero-extended.
  - idx NUM_COLORS: CTRL.
    - bit0 auto: read/write.
    - bit1 force: write-1 causes a commit; always reads 0.
    - bit2 pending: read-only.
  - idx NUM_COLORS+1: FRAME, read-only, [15:0] = frame_cnt. Writes are acknowledged and ignored.
  - any other idx: error response.

- Handshake:
  - A request is cyc & stb & !wb_ack_o & !wb_err_o.
  - On the clock edge after a request, exactly one of ack/err goes high for one cycle, then returns low. Back-to-back requests therefore terminate every other cycle.
  - Writes update state on the same edge that raises ack. Read data is valid while ack is high.
  - An err cycle changes no state and drives wb_dat_o = 0.

- Byte lanes:
  - sel[0] writes bits 7:0; sel[1] writes bits 15:8. Bits at or above COLOR_W are dropped.
  - sel[3:2] are ignored.
  - A write with sel = 0 is acknowledged and changes nothing.
  - The CTRL register uses lane 0 only.

- Vsync path: 2-flop synchroniser, then a history flop. An edge is history != VSYNC_POL and sync == VSYNC_POL. Latency from pin to edge detect is 3 clk.

- On every vsync edge, frame_cnt increments; it wraps 0xFFFF -> 0.

- Pending and commit:
  - A write to any colour entry with a nonzero effective lane sets pending.
  - Commit condition = (vsync edge & auto & pending) | force-write.
  - On commit: active <= shadow (values before the same-edge write), pending <= 0, and commit_pulse is high the next cycle.

- Simultaneous events:
  - A colour write in the same cycle as a commit: the commit takes the old shadow, pending stays 1, the new value commits at the next edge.
  - Force-write and vsync edge together: a single commit, a single pulse.
  - auto = 0: active changes only on force.

- rst asserted mid-transaction: ack/err drop to 0 at that edge and the transaction is lost; the master must retry.

Optional Feature:
- Macro: VGA_PALETTE_IRQ_EN.
- When defined:
  - Adds output irq (1 bit).
  - Adds CTRL bit3 irq_en (read/write) and CTRL bit4 irq_stat (sticky). irq_stat is set on every commit and cleared by writing 1 to bit4; a set in the same cycle wins over the clear.
  - irq = irq_stat & irq_en. All of these reset to 0.
- When undefined: no irq port, and CTRL bits 3-4 read 0 and ignore writes.

Test Plan:
- Reset, then read idx 0..3 -> each returns 0x0F8. Read CTRL -> 0x1. active_colors = {4{12'h0F8}}.
- Write 0x00000ABC with sel = 4'b0001 to idx1 -> shadow1 = 0x0BC, pending = 1, active is unchanged. Toggle vert_sync 0->1 -> 3 clk later commit_pulse = 1 and active entry1 = 0x0BC, pending = 0, FRAME = 1.
- Write CTRL = 0 (auto off), write idx0 = 0xF00, toggle vsync -> active entry0 is still 0x0F8. Write CTRL = 0x2 -> next cycle active entry0 = 0xF00, commit_pulse = 1, CTRL reads 0x0.
- Read idx 7 (NUM_COLORS = 4) -> wb_err_o high for 1 cycle, wb_ack_o stays 0, registers unchanged. Hold cyc/stb for 4 cycles -> ack/err alternates 1,0,1,0.
- Write idx2 timed so it lands on the vsync-edge cycle -> active gets the old shadow2, pending stays 1. The next vsync edge commits the new value.
- Apply 65536 vsync edges -> FRAME reads 0x0000. With VGA_PALETTE_IRQ_EN and irq_en = 1, a commit raises irq. Writing CTRL bit4 = 1 clears it.
